// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline hazard/branch/multi-cycle inputs and stall/flush controls.
// master = pipeline datapath side, slave = pipeline_hazard_ctrl.
interface pipeline_hazard_ctrl_if;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_uses_rs1;
    logic        id_uses_rs2;
    logic        id_ex_mem_read;
    logic [4:0]  id_ex_rd;
    logic        branch_resolved;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        mc_start;
    logic        mc_done;

    logic        pc_write;
    logic        if_id_write;
    logic        id_ex_write;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        ex_mem_bubble;
    logic        pc_sel;
    logic [31:0] pc_target;

    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_ex_mem_read, id_ex_rd,
               branch_resolved, branch_taken, branch_target, mc_start, mc_done,
        input  pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_flush,
               ex_mem_bubble, pc_sel, pc_target
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_ex_mem_read, id_ex_rd,
               branch_resolved, branch_taken, branch_target, mc_start, mc_done,
        output pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_flush,
               ex_mem_bubble, pc_sel, pc_target
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/freeze controller for the 5-stage pipeline with multi-cycle EX watchdog.
// Optional event counters enabled by defining HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl #(
    parameter int unsigned MC_TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    pipeline_hazard_ctrl_if.slave hz,
    output logic                 mc_error,
    output logic [31:0]          perf_stall_cnt,
    output logic [31:0]          perf_flush_cnt,
    output logic [31:0]          perf_freeze_cnt
);

    typedef enum logic {StRun, StMcWait} state_e;

    localparam logic [16:0] Timeout = 17'(MC_TIMEOUT);

    state_e      state_q, state_d;
    logic [15:0] mc_cnt_q, mc_cnt_d;
    logic        mc_error_q, mc_error_d;
    logic [16:0] mc_cnt_inc;
    logic        freeze, branch, load_use, rs_match;

    assign mc_cnt_inc = {1'b0, mc_cnt_q} + 17'd1;
    assign mc_error   = mc_error_q;

    always_comb begin
        freeze   = (state_q == StMcWait && !hz.mc_done) ||
                   (state_q == StRun && hz.mc_start && !hz.mc_done);
        rs_match = (hz.id_uses_rs1 && hz.id_rs1 == hz.id_ex_rd) ||
                   (hz.id_uses_rs2 && hz.id_rs2 == hz.id_ex_rd);
        branch   = !freeze && hz.branch_resolved && hz.branch_taken;
        load_use = !freeze && !branch && hz.id_ex_mem_read && hz.id_ex_rd != 5'd0 && rs_match;
    end

    always_comb begin
        state_d    = state_q;
        mc_cnt_d   = mc_cnt_q;
        mc_error_d = mc_error_q;
        case (state_q)
            StRun: begin
                if (hz.mc_start && !hz.mc_done) begin
                    state_d  = StMcWait;
                    mc_cnt_d = 16'd1;
                end
            end
            StMcWait: begin
                if (hz.mc_done) begin
                    state_d = StRun;
                end else begin
                    mc_cnt_d = mc_cnt_inc[15:0];
                    // Entry cycle in RUN was already frozen, so compare the post-increment count.
                    if (mc_cnt_inc == Timeout) begin
                        mc_error_d = 1'b1;
                        state_d    = StRun;
                    end
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StRun;
            mc_cnt_q   <= 16'd0;
            mc_error_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mc_cnt_q   <= mc_cnt_d;
            mc_error_q <= mc_error_d;
        end
    end

    // Controls are forced inactive while reset is held, independent of the clock.
    always_comb begin
        hz.pc_write      = 1'b1;
        hz.if_id_write   = 1'b1;
        hz.id_ex_write   = 1'b1;
        hz.if_id_flush   = 1'b0;
        hz.id_ex_flush   = 1'b0;
        hz.ex_mem_bubble = 1'b0;
        hz.pc_sel        = 1'b0;
        hz.pc_target     = 32'd0;
        if (!rst) begin
            hz.pc_write    = 1'b0;
            hz.if_id_write = 1'b0;
            hz.id_ex_write = 1'b0;
        end else if (freeze) begin
            hz.pc_write      = 1'b0;
            hz.if_id_write   = 1'b0;
            hz.id_ex_write   = 1'b0;
            hz.ex_mem_bubble = 1'b1;
        end else if (branch) begin
            hz.pc_sel      = 1'b1;
            hz.pc_target   = hz.branch_target;
            hz.if_id_flush = 1'b1;
            hz.id_ex_flush = 1'b1;
        end else if (load_use) begin
            hz.pc_write    = 1'b0;
            hz.if_id_write = 1'b0;
            hz.id_ex_flush = 1'b1;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q, flush_cnt_q, freeze_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q  <= 32'd0;
            flush_cnt_q  <= 32'd0;
            freeze_cnt_q <= 32'd0;
        end else begin
            if (load_use) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (branch)   flush_cnt_q <= flush_cnt_q + 32'd1;
            if (freeze)   freeze_cnt_q <= freeze_cnt_q + 32'd1;
        end
    end

    assign perf_stall_cnt  = stall_cnt_q;
    assign perf_flush_cnt  = flush_cnt_q;
    assign perf_freeze_cnt = freeze_cnt_q;
`else
    assign perf_stall_cnt  = 32'd0;
    assign perf_flush_cnt  = 32'd0;
    assign perf_freeze_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: expected controls queued per driven cycle,
// compared mid-cycle against the DUT.
module tb_pipeline_hazard_ctrl;

    // {pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_flush, ex_mem_bubble, pc_sel, mc_error}
    localparam logic [7:0] CtlRst = 8'b0000_0000;
    localparam logic [7:0] CtlDef = 8'b1110_0000;
    localparam logic [7:0] CtlFrz = 8'b0000_0100;
    localparam logic [7:0] CtlBr  = 8'b1111_1010;
    localparam logic [7:0] CtlLu  = 8'b0010_1000;

    typedef struct {
        string       tag;
        logic [7:0]  ctl;
        logic [31:0] tgt;
        logic [31:0] stall;
        logic [31:0] flush;
        logic [31:0] freeze;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        mc_error;
    logic [31:0] perf_stall_cnt, perf_flush_cnt, perf_freeze_cnt;

    pipeline_hazard_ctrl_if hz ();

    pipeline_hazard_ctrl #(
        .MC_TIMEOUT(4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .hz              (hz.slave),
        .mc_error        (mc_error),
        .perf_stall_cnt  (perf_stall_cnt),
        .perf_flush_cnt  (perf_flush_cnt),
        .perf_freeze_cnt (perf_freeze_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic        err_exp = 1'b0;
    logic [31:0] stall_exp = 0, flush_exp = 0, freeze_exp = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        hz.id_rs1 = 5'd0;          hz.id_rs2 = 5'd0;
        hz.id_uses_rs1 = 1'b0;     hz.id_uses_rs2 = 1'b0;
        hz.id_ex_mem_read = 1'b0;  hz.id_ex_rd = 5'd0;
        hz.branch_resolved = 1'b0; hz.branch_taken = 1'b0;
        hz.branch_target = 32'd0;
        hz.mc_start = 1'b0;        hz.mc_done = 1'b0;
    endtask

    task automatic load_use(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic u1, input logic u2);
        hz.id_ex_mem_read = 1'b1; hz.id_ex_rd = rd;
        hz.id_rs1 = rs1; hz.id_rs2 = rs2; hz.id_uses_rs1 = u1; hz.id_uses_rs2 = u2;
    endtask

    // Push expectation for the cycle being driven, compare mid-cycle, advance to next cycle.
    task automatic step(input string tag, input logic [7:0] ctl, input logic [31:0] tgt);
        exp_t e;
        exp_t o;
        logic [7:0] obs;
        e.tag    = tag;
        e.ctl    = ctl | {7'd0, err_exp};
        e.tgt    = tgt;
        e.stall  = stall_exp;
        e.flush  = flush_exp;
        e.freeze = freeze_exp;
        sb.push_back(e);
        @(negedge clk);
        o   = sb.pop_front();
        obs = {hz.pc_write, hz.if_id_write, hz.id_ex_write, hz.if_id_flush, hz.id_ex_flush,
               hz.ex_mem_bubble, hz.pc_sel, mc_error};
        chk({o.tag, "/ctl"},    {24'd0, obs},     {24'd0, o.ctl});
        chk({o.tag, "/target"}, hz.pc_target,     o.tgt);
        chk({o.tag, "/stall"},  perf_stall_cnt,   o.stall);
        chk({o.tag, "/flush"},  perf_flush_cnt,   o.flush);
        chk({o.tag, "/freeze"}, perf_freeze_cnt,  o.freeze);
`ifdef HAZARD_PERF_CNT_EN
        if (rst) begin
            if (ctl == CtlLu) stall_exp++;
            if (ctl == CtlBr) flush_exp++;
            if (ctl[2])       freeze_exp++;
        end
`endif
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        rst = 1'b0;
        step("reset", CtlRst, 32'd0);
        rst = 1'b1;
        step("idle", CtlDef, 32'd0);

        // Load-use on rs1: one stall cycle, then the load has moved on.
        load_use(5'd5, 5'd5, 5'd1, 1'b1, 1'b1);
        step("lu_rs1", CtlLu, 32'd0);
        idle();
        step("lu_clear", CtlDef, 32'd0);
        load_use(5'd7, 5'd3, 5'd7, 1'b1, 1'b1);
        step("lu_rs2", CtlLu, 32'd0);
        load_use(5'd7, 5'd3, 5'd7, 1'b1, 1'b0);
        step("lu_rs2_unused", CtlDef, 32'd0);
        load_use(5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
        step("lu_x0", CtlDef, 32'd0);
        load_use(5'd9, 5'd9, 5'd0, 1'b1, 1'b0);
        hz.id_ex_mem_read = 1'b0;
        step("not_load", CtlDef, 32'd0);

        // Branch wins over a simultaneous load-use.
        load_use(5'd5, 5'd5, 5'd1, 1'b1, 1'b0);
        hz.branch_resolved = 1'b1; hz.branch_taken = 1'b1; hz.branch_target = 32'h0000_0040;
        step("br_lu", CtlBr, 32'h0000_0040);
        idle();
        hz.branch_resolved = 1'b1; hz.branch_target = 32'h0000_1234;
        step("br_not_taken", CtlDef, 32'd0);

        // Multi-cycle op: start at cycle 0, done at cycle 3.
        idle();
        hz.mc_start = 1'b1;
        step("mc_c0", CtlFrz, 32'd0);
        hz.mc_start = 1'b0;
        step("mc_c1", CtlFrz, 32'd0);
        load_use(5'd5, 5'd5, 5'd1, 1'b1, 1'b0);
        hz.branch_resolved = 1'b1; hz.branch_taken = 1'b1; hz.branch_target = 32'h0000_0080;
        step("mc_c2_suppress", CtlFrz, 32'd0);
        hz.mc_done = 1'b1;
        step("mc_c3_done", CtlBr, 32'h0000_0080);
        idle();
        step("mc_after", CtlDef, 32'd0);
        hz.mc_start = 1'b1; hz.mc_done = 1'b1;
        step("mc_same_cycle", CtlDef, 32'd0);
        idle();
        step("mc_same_after", CtlDef, 32'd0);

        // Watchdog with MC_TIMEOUT=4.
        hz.mc_start = 1'b1;
        step("wd_c0", CtlFrz, 32'd0);
        for (int i = 1; i < 4; i++) begin
            hz.mc_start = (i == 2);
            step($sformatf("wd_c%0d", i), CtlFrz, 32'd0);
        end
        idle();
        err_exp = 1'b1;
        step("wd_error", CtlDef, 32'd0);
        load_use(5'd4, 5'd4, 5'd0, 1'b1, 1'b0);
        step("wd_run_lu", CtlLu, 32'd0);
        idle();
        step("wd_sticky", CtlDef, 32'd0);

        // Reset in the middle of a freeze.
        hz.mc_start = 1'b1;
        step("rst_mc_c0", CtlFrz, 32'd0);
        hz.mc_start = 1'b0;
        step("rst_mc_c1", CtlFrz, 32'd0);
        rst = 1'b0;
        err_exp = 1'b0;
        stall_exp = 0; flush_exp = 0; freeze_exp = 0;
        step("rst_mid_wait", CtlRst, 32'd0);
        rst = 1'b1;
        step("post_rst", CtlDef, 32'd0);
        hz.mc_done = 1'b1;
        step("post_rst_done", CtlDef, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush/freeze controller for the 5-stage pipeline. It reads the ID/EX and EX/MEM hazard inputs, the EX-stage branch resolution and the multi-cycle EX-unit handshake, and drives PC/IF-ID/ID-EX write enables, flushes and the PC redirect. It owns the only state machine that freezes the pipeline around multi-cycle EX operations and supervises them with a watchdog.

## Interface
- MC_TIMEOUT, 64: max cycles in MC_WAIT before forced release; legal 2..65535
- clk  in  1  pipeline clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- id_rs1, id_rs2  in  5 each  source registers of instruction in ID
- id_uses_rs1, id_uses_rs2  in  1 each  ID instruction actually reads that source
- id_ex_mem_read  in  1  instruction in EX is a load
- id_ex_rd  in  5  destination of instruction in EX
- branch_resolved, branch_taken  in  1 each  from EX stage
- branch_target  in  32  redirect address from EX stage
- mc_start  in  1  multi-cycle op (mul/div) present in EX this cycle
- mc_done  in  1  multi-cycle unit result valid this cycle
- pc_write, if_id_write, id_ex_write  out  1 each  register write enables
- if_id_flush, id_ex_flush  out  1 each  insert bubble into that register
- ex_mem_bubble  out  1  EX/MEM captures a NOP this cycle
- pc_sel  out  1  1 selects pc_target over PC+4
- pc_target  out  32  redirect address
- mc_error  out  1  sticky watchdog flag
- perf_stall_cnt, perf_flush_cnt, perf_freeze_cnt  out  32 each  event counters

## Operation
- States: RUN, MC_WAIT. Registered state, counter mc_cnt (16 bit), mc_error, perf counters.
- Default outputs (RUN, no event): pc_write=if_id_write=id_ex_write=1, all flushes/bubble/pc_sel=0, pc_target=0.
- Freeze condition F = (state==MC_WAIT && !mc_done) || (state==RUN && mc_start && !mc_done). Under F: pc_write=if_id_write=id_ex_write=0, ex_mem_bubble=1; branch and load-use outputs suppressed.
- Branch B = !F && branch_resolved && branch_taken: pc_sel=1, pc_target=branch_target, if_id_flush=1, id_ex_flush=1. pc_write stays 1.
- Load-use L = !F && !B && id_ex_mem_read && id_ex_rd!=0 && ((id_uses_rs1 && id_rs1==id_ex_rd) || (id_uses_rs2 && id_rs2==id_ex_rd)): pc_write=0, if_id_write=0, id_ex_flush=1.
- Priority: freeze > branch > load-use. Branch with simultaneous load-use: flush only, no stall.
- RUN -> MC_WAIT when mc_start && !mc_done; mc_cnt cleared to 1. mc_start && mc_done in same RUN cycle: no freeze, stay RUN.
- MC_WAIT: mc_done -> RUN, outputs that cycle are normal (unfrozen). Else mc_cnt increments; when mc_cnt==MC_TIMEOUT and !mc_done: mc_error<=1, -> RUN, that cycle still frozen.
- mc_start is ignored while in MC_WAIT.
- mc_error clears only on reset.

## Timing
- All hazard outputs combinational from inputs and current state; zero-cycle latency.
- Load-use: exactly one stall cycle per hazard (the load advances, hazard clears next cycle).
- Multi-cycle op with mc_done k cycles after mc_start (k>=1): exactly k frozen cycles.
- Watchdog: MC_TIMEOUT frozen cycles total, mc_error visible the cycle after the last frozen cycle.
- rst low (async): state=RUN, mc_cnt=0, mc_error=0, counters=0; while low all write enables, flushes, bubble, pc_sel are 0 and pc_target=0. Reset mid-MC_WAIT aborts the freeze immediately.

## Configuration
- HAZARD_PERF_CNT_EN defined: perf_stall_cnt +1 per L cycle, perf_flush_cnt +1 per B cycle, perf_freeze_cnt +1 per F cycle; 32-bit wrap-around.
- Undefined: counter registers absent, the three perf ports driven constant 0.

## Test plan
- EX: load x5; ID: add x6,x5,x1 (id_uses_rs1=1) -> 1 cycle pc_write=0, if_id_write=0, id_ex_flush=1; perf_stall_cnt=1.
- Load to x0 with ID reading x0 -> no stall, all defaults.
- branch_resolved=branch_taken=1, target 0x0000_0040, same cycle as load-use -> pc_sel=1, pc_target=0x40, both flushes=1, pc_write=1.
- mc_start at cycle 0, mc_done at cycle 3 -> cycles 0-2 frozen (ex_mem_bubble=1), cycle 3 normal, state RUN; perf_freeze_cnt=3.
- MC_TIMEOUT=4, mc_start, never mc_done -> 4 frozen cycles, then mc_error=1 sticky, RUN.
- rst asserted during MC_WAIT -> outputs 0 immediately, after release state RUN, mc_error=0.
